// File: rtl/valu_seq.sv
// Element sequencer for the vector ALU: decodes one vector instruction, steps the
// VALU through its elements one per cycle, and drives write-back or dot accumulation.
module valu_seq #(
    parameter int VLMAX = 8,
    parameter int IDX_W = 3,
    parameter int ELEN  = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [9:0]       vfunct_i,
    input  logic [IDX_W:0]   vl_i,
    output logic             valu_en_o,
    output logic [2:0]       valu_ctrl_o,
    output logic [IDX_W-1:0] elem_idx_o,
    input  logic [ELEN-1:0]  valu_result_i,
    output logic             wb_en_o,
    output logic [IDX_W-1:0] wb_idx_o,
    output logic [ELEN-1:0]  acc_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             illegal_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0]     CTRL_DOT = 3'b001;
    localparam logic [IDX_W:0] VLMAX_W  = (IDX_W+1)'(VLMAX);
    localparam logic [IDX_W:0] ONE_W    = (IDX_W+1)'(1);

    // Returns {legal, ctrl}; vm=0 encodings fall into the default and are illegal.
    function automatic logic [3:0] decode_f(input logic [9:0] funct);
        logic [3:0] res;
        case (funct)
            10'b0000001001: res = 4'b1_010;
            10'b0100001000: res = 4'b1_110;
            10'b0000001111: res = 4'b1_000;
            10'b0000001110: res = 4'b1_001;
            default:        res = 4'b0_000;
        endcase
        return res;
    endfunction

    state_t           state_q;
    logic             valu_en_q;
    logic             res_vld_q;
    logic             wb_en_q;
    logic             is_dot_q;
    logic             done_q;
    logic             illegal_q;
    logic [2:0]       ctrl_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] wb_idx_q;
    logic [ELEN-1:0]  acc_q;

    logic [3:0]       dec_s;
    logic [IDX_W:0]   n_s;
    logic             accept_s;

    // Request decode, clamped length and handshake.
    always_comb begin
        dec_s    = decode_f(vfunct_i);
        accept_s = req_valid_i & (state_q == ST_IDLE);
        if (vl_i > VLMAX_W) begin
            n_s = VLMAX_W;
        end else begin
            n_s = vl_i;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            valu_en_q <= 1'b0;
            res_vld_q <= 1'b0;
            wb_en_q   <= 1'b0;
            is_dot_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= 3'b000;
            idx_q     <= '0;
            last_q    <= '0;
            wb_idx_q  <= '0;
            acc_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            valu_en_q <= 1'b0;
            // Results arrive one cycle after issue; write-back trails by the same cycle.
            res_vld_q <= valu_en_q;
            wb_en_q   <= valu_en_q & ~is_dot_q;
            wb_idx_q  <= idx_q;
            if (res_vld_q && is_dot_q) begin
                acc_q <= acc_q + valu_result_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (!dec_s[3]) begin
                            illegal_q <= 1'b1;
                        end else if (n_s == '0) begin
                            acc_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            acc_q     <= '0;
                            ctrl_q    <= dec_s[2:0];
                            is_dot_q  <= (dec_s[2:0] == CTRL_DOT);
                            last_q    <= IDX_W'(n_s - ONE_W);
                            idx_q     <= '0;
                            valu_en_q <= 1'b1;
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (idx_q == last_q) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        idx_q     <= idx_q + IDX_W'(1);
                        valu_en_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign valu_en_o   = valu_en_q;
    assign valu_ctrl_o = ctrl_q;
    assign elem_idx_o  = idx_q;
    assign wb_en_o     = wb_en_q;
    assign wb_idx_o    = wb_idx_q;
    assign acc_o       = acc_q;
    assign done_o      = done_q;
    assign illegal_o   = illegal_q;

endmodule
